cam_pixel_decimator: RTL and testbench
======================================

CAM_PIXEL_DECIMATOR -- requirements
Module: cam_pixel_decimator

Interface
REQ-001 The block SHALL have parameter H_DEC, default 1, meaning horizontal decimation factor (1..8): keep every H_DEC-th pixel of a line.
REQ-002 The block SHALL have parameter V_DEC, default 1, meaning vertical decimation factor (1..8): keep every V_DEC-th line.
REQ-003 The block SHALL have parameter MAX_X, default 176, meaning decimated pixels per line written; beyond it, drop.
REQ-004 The block SHALL have parameter MAX_Y, default 144, meaning decimated lines per frame written; beyond it, drop.
REQ-005 The block SHALL have parameter ADDR_W, default 15, meaning width of x_addr/y_addr.
REQ-006 The block SHALL have parameter CNT_W, default 15, meaning width of saturating classification counters.
REQ-007 The block SHALL have port pclk, input, 1, camera pixel clock; all logic on rising edge.
REQ-008 The block SHALL have port reset, input, 1, and reset SHALL be synchronous, active-high, on clock pclk.
REQ-009 The block SHALL have input ports href (1, line valid), vsync (1, frame sync, high = between frames) and din (8, RGB565 byte stream, high byte first).
REQ-010 The block SHALL have output ports pix_out (8, RGB332 pixel), x_addr (ADDR_W, decimated column), y_addr (ADDR_W, decimated row) and wen (1, one-cycle write strobe).
REQ-011 The block SHALL have output ports frame_done (1, one-cycle pulse at vsync rise), overflow (1, sticky per frame, clip occurred), color (2; 0 none, 1 red, 2 blue) and color_valid (1, one-cycle pulse).

Function
REQ-012 The FSM SHALL have states WAIT_VS, FRAME_IDLE, BYTE1 and BYTE2.
REQ-013 In WAIT_VS, the FSM SHALL go to FRAME_IDLE on a vsync falling edge.
REQ-014 In FRAME_IDLE, the FSM SHALL go to BYTE1 when href=1, else stay.
REQ-015 In BYTE1, the FSM SHALL go to BYTE2 when href=1; if href=0, it SHALL discard the partial pixel, emit no wen and go to FRAME_IDLE.
REQ-016 In BYTE2, the FSM SHALL go to BYTE1 when href=1, else to FRAME_IDLE (end of line).
REQ-017 vsync=1 in any state SHALL abort the current line and go to WAIT_VS; vsync has priority over href.
REQ-018 BYTE1 SHALL latch R=din[7:5] and G=din[2:0]; BYTE2 SHALL take B=din[4:3]; pix_out = {R,G,B}.
REQ-019 pix_out, x_addr, y_addr and wen SHALL be registered and valid together on the cycle after the BYTE2 byte is sampled (latency 1 pclk).
REQ-020 A raw column counter SHALL count completed pixels per line and a raw line counter SHALL count lines with at least one completed pixel; both clear at frame start.
REQ-021 wen SHALL assert only if raw column mod H_DEC = 0, raw line mod V_DEC = 0, x < MAX_X and y < MAX_Y.
REQ-022 x_addr SHALL increment after each written pixel, and SHALL be 0 at line start.
REQ-023 y_addr SHALL increment at the end of each kept line that wrote at least one pixel.
REQ-024 A pixel dropped for x >= MAX_X or y >= MAX_Y SHALL set overflow; overflow SHALL clear only at the next vsync rise.
REQ-025 frame_done SHALL pulse for one cycle on the vsync rising edge, which SHALL also zero x_addr and y_addr.
REQ-026 Decimation counters SHALL use internal mod counters, with no divider.

Reset
REQ-027 On reset the FSM SHALL enter WAIT_VS.
REQ-028 On reset pix_out, x_addr, y_addr, wen, frame_done, overflow, color and color_valid SHALL be 0, and all counters SHALL be 0.
REQ-029 Reset mid-line SHALL discard any partial pixel, and no wen SHALL issue on the reset cycle.

Configuration
REQ-030 Macro COLOR_CLASSIFY_EN defined: each written pixel SHALL increment exactly one of red_cnt (R>4, G<4, B<2), blue_cnt (R<4, G<4, B>2) or other_cnt, saturating at 2^CNT_W-1.
REQ-031 Macro COLOR_CLASSIFY_EN defined: at the vsync rise, color SHALL become 1 if red>blue and red>other, 2 if blue>red and blue>other, else 0; color_valid SHALL pulse with frame_done and the counters SHALL clear.
REQ-032 Macro COLOR_CLASSIFY_EN undefined: counters SHALL be absent, and color and color_valid SHALL be tied to 0.

Structure
REQ-033 Shared package cam_pkg SHALL hold the FSM state encoding, the color codes (NONE=0, RED=1, BLUE=2) and the classification threshold constants.
REQ-034 Classification SHALL be the sub-module color_classifier (pixel+valid in; counters, color, color_valid out), instantiated only under COLOR_CLASSIFY_EN.

Verification
REQ-035 Test: H_DEC=V_DEC=1, one 4-pixel line with bytes E0,1F repeated -> 4 wen pulses, pix_out=0xE3, x_addr 0..3, y_addr 0.
REQ-036 Test: H_DEC=2, V_DEC=2, 4 lines of 8 pixels -> 8 wen total, x_addr 0..3, y_addr 0..1.
REQ-037 Test: MAX_X=4, one 6-pixel line -> 4 wen, overflow=1 until the next vsync rise, then 0.
REQ-038 Test: href drops after BYTE1 of pixel 3 -> no wen for pixel 3, y_addr increments.
REQ-039 Test: COLOR_CLASSIFY_EN with a frame of 10 red (0xE0,0x00), 3 blue (0x00,0x18) and 2 other pixels -> at vsync, color=1 and color_valid pulses for 1 cycle.
REQ-040 Test: reset asserted mid-line -> all outputs 0 next cycle; after reset the block stays in WAIT_VS until vsync falls.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared definitions for the camera pixel decimator: FSM encoding, colour codes
// and the RGB332 classification thresholds.
package cam_pkg;

   typedef enum logic [1:0] {
      WAIT_VS    = 2'd0,
      FRAME_IDLE = 2'd1,
      BYTE1      = 2'd2,
      BYTE2      = 2'd3
   } state_e;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      RED  = 2'd1,
      BLUE = 2'd2
   } color_e;

   // Decimation phase counters cover factors 1..8.
   localparam int PH_W = 3;

   // Red: R > 4, G < 4, B < 2.  Blue: R < 4, G < 4, B > 2.
   localparam logic [2:0] RED_R_MIN  = 3'd4;
   localparam logic [2:0] RED_G_MAX  = 3'd4;
   localparam logic [1:0] RED_B_MAX  = 2'd2;
   localparam logic [2:0] BLUE_R_MAX = 3'd4;
   localparam logic [2:0] BLUE_G_MAX = 3'd4;
   localparam logic [1:0] BLUE_B_MIN = 2'd2;

   function automatic logic is_red(input logic [7:0] pix);
      return (pix[7:5] > RED_R_MIN) && (pix[4:2] < RED_G_MAX) && (pix[1:0] < RED_B_MAX);
   endfunction

   function automatic logic is_blue(input logic [7:0] pix);
      return (pix[7:5] < BLUE_R_MAX) && (pix[4:2] < BLUE_G_MAX) && (pix[1:0] > BLUE_B_MIN);
   endfunction

endpackage

// File: rtl/cam_pixel_decimator_color_classifier.sv
// Per-frame colour histogram of written RGB332 pixels; reports the dominant
// colour at frame end and clears the counters.
module color_classifier
   import cam_pkg::*;
#(
   parameter int CNT_W = 15
) (
   input  logic             pclk,
   input  logic             reset,
   input  logic [7:0]       pix_i,
   input  logic             valid_i,
   input  logic             frame_end_i,
   output logic [CNT_W-1:0] red_cnt_o,
   output logic [CNT_W-1:0] blue_cnt_o,
   output logic [CNT_W-1:0] other_cnt_o,
   output logic [1:0]       color_o,
   output logic             color_valid_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] red_q, red_d, blue_q, blue_d, other_q, other_d;
   logic [1:0]       color_q, color_d;
   logic             cv_q, cv_d;

   // Saturating histogram update and end-of-frame verdict.
   always_comb begin
      red_d   = red_q;
      blue_d  = blue_q;
      other_d = other_q;
      color_d = color_q;
      cv_d    = 1'b0;
      if (frame_end_i) begin
         if ((red_q > blue_q) && (red_q > other_q)) begin
            color_d = RED;
         end else if ((blue_q > red_q) && (blue_q > other_q)) begin
            color_d = BLUE;
         end else begin
            color_d = NONE;
         end
         cv_d    = 1'b1;
         red_d   = {CNT_W{1'b0}};
         blue_d  = {CNT_W{1'b0}};
         other_d = {CNT_W{1'b0}};
      end else if (valid_i) begin
         if (is_red(pix_i)) begin
            red_d = (red_q == CNT_MAX) ? red_q : red_q + CNT_ONE;
         end else if (is_blue(pix_i)) begin
            blue_d = (blue_q == CNT_MAX) ? blue_q : blue_q + CNT_ONE;
         end else begin
            other_d = (other_q == CNT_MAX) ? other_q : other_q + CNT_ONE;
         end
      end else begin
         cv_d = 1'b0;
      end
   end

   // Counter and verdict registers.
   always_ff @(posedge pclk) begin
      if (reset) begin
         red_q   <= {CNT_W{1'b0}};
         blue_q  <= {CNT_W{1'b0}};
         other_q <= {CNT_W{1'b0}};
         color_q <= 2'd0;
         cv_q    <= 1'b0;
      end else begin
         red_q   <= red_d;
         blue_q  <= blue_d;
         other_q <= other_d;
         color_q <= color_d;
         cv_q    <= cv_d;
      end
   end

   assign red_cnt_o     = red_q;
   assign blue_cnt_o    = blue_q;
   assign other_cnt_o   = other_q;
   assign color_o       = color_q;
   assign color_valid_o = cv_q;

endmodule

// File: rtl/cam_pixel_decimator.sv
// Camera RGB565 byte stream to decimated, clipped RGB332 frame-buffer writes.
// Optional per-frame colour classification is enabled by COLOR_CLASSIFY_EN.
module cam_pixel_decimator
   import cam_pkg::*;
#(
   parameter int H_DEC  = 1,
   parameter int V_DEC  = 1,
   parameter int MAX_X  = 176,
   parameter int MAX_Y  = 144,
   parameter int ADDR_W = 15,
   parameter int CNT_W  = 15
) (
   input  logic              pclk,
   input  logic              reset,
   input  logic              href,
   input  logic              vsync,
   input  logic [7:0]        din,
   output logic [7:0]        pix_out,
   output logic [ADDR_W-1:0] x_addr,
   output logic [ADDR_W-1:0] y_addr,
   output logic              wen,
   output logic              frame_done,
   output logic              overflow,
`ifdef COLOR_CLASSIFY_EN
   output logic [CNT_W-1:0]  red_cnt,
   output logic [CNT_W-1:0]  blue_cnt,
   output logic [CNT_W-1:0]  other_cnt,
`endif
   output logic [1:0]        color,
   output logic              color_valid
);

   localparam logic [PH_W-1:0]   H_LAST   = PH_W'(H_DEC - 1);
   localparam logic [PH_W-1:0]   V_LAST   = PH_W'(V_DEC - 1);
   localparam logic [PH_W-1:0]   PH_ZERO  = {PH_W{1'b0}};
   localparam logic [PH_W-1:0]   PH_ONE   = {{(PH_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] MAX_X_A   = ADDR_W'(MAX_X);
   localparam logic [ADDR_W-1:0] MAX_Y_A   = ADDR_W'(MAX_Y);

   state_e            state_q, state_d;
   logic              vsync_q;
   logic [5:0]        rg_q, rg_d;
   logic [PH_W-1:0]   col_ph_q, col_ph_d, line_ph_q, line_ph_d;
   logic              line_pix_q, line_pix_d, line_wr_q, line_wr_d;
   logic [7:0]        pix_out_q, pix_out_d;
   logic [ADDR_W-1:0] x_addr_q, x_addr_d, y_addr_q, y_addr_d;
   logic              wen_q, wen_d, frame_done_q, frame_done_d, overflow_q, overflow_d;

   logic vs_rise_s, vs_fall_s, accept_b1_s, pix_done_s, line_end_s;
   logic kept_s, room_s, write_s, drop_s;

   assign vs_rise_s   = vsync & ~vsync_q;
   assign vs_fall_s   = ~vsync & vsync_q;
   // The state names the byte most recently accepted, so a pixel completes on
   // the edge that leaves BYTE1 with href still high.
   assign accept_b1_s = href & ~vsync & ((state_q == FRAME_IDLE) || (state_q == BYTE2));
   assign pix_done_s  = href & ~vsync & (state_q == BYTE1);
   assign line_end_s  = ~href & ~vsync & ((state_q == BYTE1) || (state_q == BYTE2));
   assign kept_s      = (col_ph_q == PH_ZERO) && (line_ph_q == PH_ZERO);
   assign room_s      = (x_addr_q < MAX_X_A) && (y_addr_q < MAX_Y_A);
   assign write_s     = pix_done_s & kept_s & room_s;
   assign drop_s      = pix_done_s & kept_s & ~room_s;

   // Line/pixel framing FSM; vsync high aborts everything.
   always_comb begin
      state_d = state_q;
      if (vsync) begin
         state_d = WAIT_VS;
      end else begin
         case (state_q)
            WAIT_VS:    state_d = vs_fall_s ? FRAME_IDLE : WAIT_VS;
            FRAME_IDLE: state_d = href ? BYTE1 : FRAME_IDLE;
            BYTE1:      state_d = href ? BYTE2 : FRAME_IDLE;
            BYTE2:      state_d = href ? BYTE1 : FRAME_IDLE;
            default:    state_d = WAIT_VS;
         endcase
      end
   end

   // Decimation phases, addresses and write-port outputs.
   always_comb begin
      rg_d         = accept_b1_s ? {din[7:5], din[2:0]} : rg_q;
      col_ph_d     = col_ph_q;
      line_ph_d    = line_ph_q;
      line_pix_d   = line_pix_q;
      line_wr_d    = line_wr_q;
      pix_out_d    = pix_out_q;
      x_addr_d     = wen_q ? x_addr_q + ADDR_ONE : x_addr_q;
      y_addr_d     = y_addr_q;
      wen_d        = 1'b0;
      frame_done_d = 1'b0;
      overflow_d   = overflow_q;
      if (vs_rise_s) begin
         col_ph_d     = PH_ZERO;
         line_ph_d    = PH_ZERO;
         line_pix_d   = 1'b0;
         line_wr_d    = 1'b0;
         x_addr_d     = ADDR_ZERO;
         y_addr_d     = ADDR_ZERO;
         overflow_d   = 1'b0;
         frame_done_d = 1'b1;
      end else if (pix_done_s) begin
         col_ph_d   = (col_ph_q == H_LAST) ? PH_ZERO : col_ph_q + PH_ONE;
         line_pix_d = 1'b1;
         if (write_s) begin
            pix_out_d = {rg_q, din[4:3]};
            wen_d     = 1'b1;
            line_wr_d = 1'b1;
         end else begin
            overflow_d = overflow_q | drop_s;
         end
      end else if (line_end_s) begin
         col_ph_d   = PH_ZERO;
         x_addr_d   = ADDR_ZERO;
         line_pix_d = 1'b0;
         line_wr_d  = 1'b0;
         if (line_pix_q) begin
            line_ph_d = (line_ph_q == V_LAST) ? PH_ZERO : line_ph_q + PH_ONE;
         end else begin
            line_ph_d = line_ph_q;
         end
         y_addr_d = line_wr_q ? y_addr_q + ADDR_ONE : y_addr_q;
      end else begin
         wen_d = 1'b0;
      end
   end

   // State and output registers.
   always_ff @(posedge pclk) begin
      if (reset) begin
         state_q      <= WAIT_VS;
         vsync_q      <= 1'b0;
         rg_q         <= 6'd0;
         col_ph_q     <= PH_ZERO;
         line_ph_q    <= PH_ZERO;
         line_pix_q   <= 1'b0;
         line_wr_q    <= 1'b0;
         pix_out_q    <= 8'd0;
         x_addr_q     <= ADDR_ZERO;
         y_addr_q     <= ADDR_ZERO;
         wen_q        <= 1'b0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         vsync_q      <= vsync;
         rg_q         <= rg_d;
         col_ph_q     <= col_ph_d;
         line_ph_q    <= line_ph_d;
         line_pix_q   <= line_pix_d;
         line_wr_q    <= line_wr_d;
         pix_out_q    <= pix_out_d;
         x_addr_q     <= x_addr_d;
         y_addr_q     <= y_addr_d;
         wen_q        <= wen_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
      end
   end

   assign pix_out    = pix_out_q;
   assign x_addr     = x_addr_q;
   assign y_addr     = y_addr_q;
   assign wen        = wen_q;
   assign frame_done = frame_done_q;
   assign overflow   = overflow_q;

`ifdef COLOR_CLASSIFY_EN
   color_classifier #(.CNT_W(CNT_W)) u_color_classifier (
      .pclk          (pclk),
      .reset         (reset),
      .pix_i         ({rg_q, din[4:3]}),
      .valid_i       (write_s),
      .frame_end_i   (vs_rise_s),
      .red_cnt_o     (red_cnt),
      .blue_cnt_o    (blue_cnt),
      .other_cnt_o   (other_cnt),
      .color_o       (color),
      .color_valid_o (color_valid)
   );
`else
   assign color       = 2'b00;
   assign color_valid = 1'b0;
`endif

endmodule

// File: tb/tb_cam_pixel_decimator.sv
// Self-checking bench: three decimator configurations fed the same random
// camera stream, checked against a line-level arithmetic model.
module tb_cam_pixel_decimator;

   localparam int HD[3] = '{1, 2, 1};
   localparam int VD[3] = '{1, 2, 1};
   localparam int MX[3] = '{176, 176, 4};
   localparam int MY[3] = '{144, 144, 2};
`ifdef COLOR_CLASSIFY_EN
   localparam bit CLS = 1'b1;
`else
   localparam bit CLS = 1'b0;
`endif

   logic       pclk = 1'b0;
   logic       reset, href, vsync;
   logic [7:0] din;

   logic [7:0]  pix_w [3];
   logic [14:0] x_w [3];
   logic [14:0] y_w [3];
   logic        wen_w [3];
   logic        fd_w [3];
   logic        ov_w [3];
   logic [1:0]  col_w [3];
   logic        cv_w [3];
`ifdef COLOR_CLASSIFY_EN
   logic [14:0] rc_w [3];
   logic [14:0] bc_w [3];
   logic [14:0] oc_w [3];
`endif

   for (genvar k = 0; k < 3; k++) begin : g_dut
      cam_pixel_decimator #(
         .H_DEC(HD[k]), .V_DEC(VD[k]), .MAX_X(MX[k]), .MAX_Y(MY[k]),
         .ADDR_W(15), .CNT_W(15)
      ) u_dut (
         .pclk(pclk), .reset(reset), .href(href), .vsync(vsync), .din(din),
         .pix_out(pix_w[k]), .x_addr(x_w[k]), .y_addr(y_w[k]), .wen(wen_w[k]),
         .frame_done(fd_w[k]), .overflow(ov_w[k]),
`ifdef COLOR_CLASSIFY_EN
         .red_cnt(rc_w[k]), .blue_cnt(bc_w[k]), .other_cnt(oc_w[k]),
`endif
         .color(col_w[k]), .color_valid(cv_w[k])
      );
   end

   always #5 pclk = ~pclk;

   int total = 0;
   int bad   = 0;
   logic [33:0] obs_q[$];
   logic [33:0] exp_q[$];
   logic [7:0]  cur_line[$];
   int  m_line[3];
   int  m_y[3];
   bit  m_ovf[3];
   bit  m_active;

   function automatic logic [33:0] mk(input int k, input int y, input int x, input logic [7:0] p);
      logic [31:0] kk, yy, xx;
      kk = k; yy = y; xx = x;
      return {kk[1:0], yy[11:0], xx[11:0], p};
   endfunction

   // Capture every write strobe of every instance.
   always @(negedge pclk) begin
      for (int k = 0; k < 3; k++) begin
         if (wen_w[k] === 1'b1) obs_q.push_back(mk(k, int'(y_w[k]), int'(x_w[k]), pix_w[k]));
      end
   end

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      total++;
      assert (o === e) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   function automatic int count_inst(input int k);
      int n = 0;
      foreach (obs_q[i]) if (int'(obs_q[i][33:32]) == k) n++;
      return n;
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 3; k++) begin
         m_line[k] = 0; m_y[k] = 0; m_ovf[k] = 1'b0;
      end
   endtask

   // Expected writes for one line: pixel c of raw line L is kept when
   // c%H==0 and L%V==0, lands at (c/H, kept-lines-so-far) unless clipped.
   task automatic model_line();
      bit kept[3];
      bit wrote[3];
      int x;
      if (m_active && cur_line.size() > 0) begin
         for (int k = 0; k < 3; k++) begin
            kept[k] = (m_line[k] % VD[k]) == 0;
            wrote[k] = 1'b0;
         end
         for (int c = 0; c < cur_line.size(); c++) begin
            for (int k = 0; k < 3; k++) begin
               if (kept[k] && (c % HD[k]) == 0) begin
                  x = c / HD[k];
                  if (x < MX[k] && m_y[k] < MY[k]) begin
                     exp_q.push_back(mk(k, m_y[k], x, cur_line[c]));
                     wrote[k] = 1'b1;
                  end else begin
                     m_ovf[k] = 1'b1;
                  end
               end
            end
         end
         for (int k = 0; k < 3; k++) begin
            if (wrote[k]) m_y[k]++;
            m_line[k]++;
         end
      end
      cur_line.delete();
   endtask

   task automatic send_line(input int npix, input bit partial, input bit fixed,
                            input logic [7:0] fb1, input logic [7:0] fb2);
      logic [7:0] b1, b2;
      for (int i = 0; i < npix; i++) begin
         b1 = fixed ? fb1 : 8'($urandom);
         b2 = fixed ? fb2 : 8'($urandom);
         href = 1'b1; din = b1; tick();
         din = b2; tick();
         cur_line.push_back({b1[7:5], b1[2:0], b2[4:3]});
      end
      if (partial) begin
         href = 1'b1; din = 8'($urandom); tick();
      end
      href = 1'b0; din = 8'h00;
      repeat (3) tick();
      model_line();
   endtask

   task automatic check_frame(input string tag);
      int n;
      repeat (2) tick();
      chk({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk({tag, "_wr"}, 64'(obs_q[i]), 64'(exp_q[i]));
      for (int k = 0; k < 3; k++) chk($sformatf("%s_ovf%0d", tag, k), 64'(ov_w[k]), 64'(m_ovf[k]));
      obs_q.delete();
      exp_q.delete();
   endtask

   task automatic vsync_pulse();
      href = 1'b0; vsync = 1'b1; tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("fd_hi%0d", k), 64'(fd_w[k]), 64'd1);
         chk($sformatf("xy_zero%0d", k), 64'({x_w[k], y_w[k]}), 64'd0);
         chk($sformatf("ovf_clr%0d", k), 64'(ov_w[k]), 64'd0);
         chk($sformatf("cv_hi%0d", k), 64'(cv_w[k]), 64'(CLS));
      end
      tick();
      chk("fd_lo", 64'(fd_w[0]), 64'd0);
      chk("cv_lo", 64'(cv_w[0]), 64'd0);
      tick();
      vsync = 1'b0;
      repeat (2) tick();
      model_clear();
      m_active = 1'b1;
   endtask

   initial begin
      int nl;
      reset = 1'b1; href = 1'b0; vsync = 1'b0; din = 8'h00;
      m_active = 1'b0;
      model_clear();
      repeat (3) tick();
      for (int k = 0; k < 3; k++)
         chk($sformatf("rst_out%0d", k),
             64'({pix_w[k], x_w[k], y_w[k], wen_w[k], fd_w[k], ov_w[k], col_w[k], cv_w[k]}), 64'd0);
      reset = 1'b0;
      tick();

      // No frame yet: pixels before the first vsync are ignored.
      send_line(3, 1'b0, 1'b0, 8'h00, 8'h00);
      check_frame("prevs");

      vsync_pulse();
      send_line(4, 1'b0, 1'b1, 8'hE0, 8'h1F);
      chk("a_cnt", 64'(count_inst(0)), 64'd4);
      chk("a_pix", 64'(obs_q.size() > 0 ? obs_q[0][7:0] : 8'h00), 64'hE3);
      check_frame("a");

      vsync_pulse();
      repeat (4) send_line(8, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("b_cnt_dec", 64'(count_inst(1)), 64'd8);
      check_frame("b");

      vsync_pulse();
      send_line(6, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("c_cnt_clip", 64'(count_inst(2)), 64'd4);
      chk("c_ovf_set", 64'(ov_w[2]), 64'd1);
      check_frame("c");

      vsync_pulse();
      send_line(2, 1'b1, 1'b0, 8'h00, 8'h00);
      send_line(2, 1'b0, 1'b0, 8'h00, 8'h00);
      chk("d_cnt", 64'(count_inst(0)), 64'd4);
      check_frame("d");

      for (int f = 0; f < 5; f++) begin
         vsync_pulse();
         nl = $urandom_range(2, 6);
         for (int l = 0; l < nl; l++)
            send_line($urandom_range(0, 9), ($urandom_range(0, 3) == 0), 1'b0, 8'h00, 8'h00);
         check_frame($sformatf("rnd%0d", f));
      end

      // Reset in the middle of a pixel.
      vsync_pulse();
      send_line(2, 1'b0, 1'b0, 8'h00, 8'h00);
      href = 1'b1; din = 8'($urandom); tick();
      din = 8'($urandom); reset = 1'b1; tick();
      href = 1'b0;
      for (int k = 0; k < 3; k++)
         chk($sformatf("mid_rst%0d", k),
             64'({pix_w[k], x_w[k], y_w[k], wen_w[k], fd_w[k], ov_w[k], col_w[k], cv_w[k]}), 64'd0);
      reset = 1'b0;
      model_clear();
      m_active = 1'b0;
      tick();
      send_line(3, 1'b0, 1'b0, 8'h00, 8'h00);
      check_frame("post_rst");
      vsync_pulse();
      send_line(5, 1'b0, 1'b0, 8'h00, 8'h00);
      check_frame("resume");

`ifdef COLOR_CLASSIFY_EN
      vsync_pulse();
      send_line(10, 1'b0, 1'b1, 8'hE0, 8'h00);
      send_line(3, 1'b0, 1'b1, 8'h00, 8'h18);
      send_line(2, 1'b0, 1'b1, 8'hFF, 8'hFF);
      chk("cls_red_cnt", 64'(rc_w[0]), 64'd10);
      check_frame("cls");
      vsync = 1'b1; tick();
      chk("cls_color", 64'(col_w[0]), 64'd1);
      chk("cls_cv_hi", 64'(cv_w[0]), 64'd1);
      tick();
      chk("cls_cv_lo", 64'(cv_w[0]), 64'd0);
      vsync = 1'b0;
      repeat (2) tick();
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
